// File: rtl/n101_i2c_master_byte_ctrl.sv
// rtl/n101_i2c_master_byte_ctrl.sv - I2C master byte sequencer
// Splits one byte command into single-bit commands for the bit controller.
module n101_i2c_master_byte_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_al,
  output logic [3:0] bit_cmd,
  output logic       bit_din,
  input  logic       bit_ack,
  input  logic       bit_dout,
  input  logic       bit_al
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  logic [2:0] state;
  logic [7:0] sr;
  logic [2:0] cnt;
  logic       al_q;
  logic       go;

  // The register block needs one cycle to drop its command bits after cmd_ack.
  assign go   = (read | write | stop) & ~cmd_ack;
  assign dout = sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cmd <= CMD_NOP;
      bit_din <= 1'b0;
      cmd_ack <= 1'b0;
      ack_out <= 1'b0;
      i2c_al  <= 1'b0;
      sr      <= 8'h00;
      cnt     <= 3'd0;
      al_q    <= 1'b0;
    end else begin
      al_q    <= bit_al;
      cmd_ack <= 1'b0;
      i2c_al  <= 1'b0;
      if (bit_al) begin
        // Abort; i2c_al only pulses on the rising edge of a held bit_al.
        i2c_al  <= ~al_q;
        state   <= ST_IDLE;
        bit_cmd <= CMD_NOP;
        cnt     <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (go) begin
              sr  <= din;
              cnt <= 3'd7;
              if (start) begin
                state   <= ST_START;
                bit_cmd <= CMD_START;
              end else if (read) begin
                state   <= ST_READ;
                bit_cmd <= CMD_READ;
              end else if (write) begin
                state   <= ST_WRITE;
                bit_cmd <= CMD_WRITE;
                bit_din <= din[7];
              end else begin
                state   <= ST_STOP;
                bit_cmd <= CMD_STOP;
              end
            end
          end
          ST_START: begin
            if (bit_ack) begin
              if (read) begin
                state   <= ST_READ;
                bit_cmd <= CMD_READ;
              end else begin
                state   <= ST_WRITE;
                bit_cmd <= CMD_WRITE;
                bit_din <= sr[7];
              end
            end
          end
          ST_WRITE, ST_READ: begin
            if (bit_ack) begin
              sr <= {sr[6:0], bit_dout};
              if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
                if (state == ST_WRITE) bit_din <= sr[6];
              end else begin
                state <= ST_ACK;
                if (state == ST_WRITE) begin
                  bit_cmd <= CMD_READ;
                end else begin
                  bit_cmd <= CMD_WRITE;
                  bit_din <= ack_in;
                end
              end
            end
          end
          ST_ACK: begin
            if (bit_ack) begin
              if (!read) ack_out <= bit_dout;
              if (stop) begin
                state   <= ST_STOP;
                bit_cmd <= CMD_STOP;
              end else begin
                state   <= ST_IDLE;
                bit_cmd <= CMD_NOP;
                cmd_ack <= 1'b1;
              end
            end
          end
          ST_STOP: begin
            if (bit_ack) begin
              state   <= ST_IDLE;
              bit_cmd <= CMD_NOP;
              cmd_ack <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            bit_cmd <= CMD_NOP;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n101_i2c_master_byte_ctrl.sv
// tb/tb_n101_i2c_master_byte_ctrl.sv - bench for the I2C master byte sequencer
// A bit-controller model answers each bit command; expected command streams come from a byte-level model.
module tb_n101_i2c_master_byte_ctrl;

  localparam logic [3:0] NOP   = 4'b0000;
  localparam logic [3:0] START = 4'b0001;
  localparam logic [3:0] STOP  = 4'b0010;
  localparam logic [3:0] WRITE = 4'b0100;
  localparam logic [3:0] READ  = 4'b1000;

  logic       clk, rst, start, stop, read, write, ack_in;
  logic [7:0] din, dout;
  logic       cmd_ack, ack_out, i2c_al, bit_din, bit_ack, bit_dout, bit_al;
  logic [3:0] bit_cmd;

  n101_i2c_master_byte_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
    .i2c_al(i2c_al), .bit_cmd(bit_cmd), .bit_din(bit_din), .bit_ack(bit_ack),
    .bit_dout(bit_dout), .bit_al(bit_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0, n_err = 0;
  int n_issued = 0, n_acks = 0, n_al = 0, n_cack = 0;

  logic [4:0] exp_q[$];
  logic       rd_q[$];
  logic       dflt_dout = 1'b0;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ack_out = 1'b0;
  logic       cmd_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-controller model: acknowledges each new command five cycles after it appears.
  initial begin
    int phase, bcnt;
    logic [3:0] held;
    phase = 0; bcnt = 0; held = NOP;
    bit_ack = 1'b0; bit_dout = 1'b0;
    forever begin
      @(negedge clk);
      bit_ack = 1'b0;
      if (rst || bit_al) begin
        phase = 0;
      end else if (phase == 0) begin
        if (bit_cmd != NOP) begin
          held = bit_cmd; bcnt = 1; phase = 1;
        end
      end else begin
        bcnt++;
        if (bcnt == 5) begin
          if (held == READ && rd_q.size() > 0) bit_dout = rd_q.pop_front();
          else bit_dout = dflt_dout;
          bit_ack = 1'b1;
          phase = 0;
        end
      end
    end
  end

  // Compare process: checks handshake, command stream and completion every cycle.
  initial begin
    logic ack_prev, al_prev, al_prev2, last_prev, last, is_new, prev_din;
    logic [3:0] prev_cmd;
    logic [4:0] e;
    ack_prev = 0; al_prev = 0; al_prev2 = 0; last_prev = 0; prev_din = 0; prev_cmd = NOP;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        ack_prev = 0; al_prev = 0; al_prev2 = 0; last_prev = 0; prev_din = 0; prev_cmd = NOP;
        continue;
      end
      chk("i2c_al", i2c_al, al_prev & ~al_prev2);
      if (i2c_al) n_al++;
      chk("cmd_ack", cmd_ack, last_prev);
      if (cmd_ack) n_cack++;
      if (al_prev) chk("al_nop", bit_cmd, NOP);
      if (last_prev) begin
        chk("dout_done", dout, exp_dout);
        chk("ack_out_done", ack_out, exp_ack_out);
        cmd_active = 1'b0;
      end
      is_new = (bit_cmd != NOP) && (prev_cmd == NOP || ack_prev);
      if (ack_prev && cmd_active && exp_q.size() > 0) chk("cmd_after_ack", is_new, 1);
      if (is_new) begin
        n_issued++;
        chk("cmd_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bit_cmd", bit_cmd, e[4:1]);
          if (e[4:1] == WRITE) chk("bit_din", bit_din, e[0]);
        end
      end else if (bit_cmd != NOP) begin
        chk("cmd_hold", bit_cmd, prev_cmd);
        if (bit_cmd == WRITE) chk("din_hold", bit_din, prev_din);
      end
      if (bit_ack) n_acks++;
      last = bit_ack && cmd_active && exp_q.size() == 0 && !bit_al;
      ack_prev = bit_ack; al_prev2 = al_prev; al_prev = bit_al;
      prev_cmd = bit_cmd; prev_din = bit_din; last_prev = last;
    end
  end

  // Byte-level model: builds the expected bit-command stream and final results.
  task automatic issue(input logic s, input logic p, input logic r, input logic w, input logic ai,
                       input logic [7:0] d, input logic [7:0] rbyte, input logic ackbit,
                       input logic dflt);
    exp_q.delete(); rd_q.delete(); dflt_dout = dflt;
    if (r | w) begin
      if (s) exp_q.push_back({START, 1'b0});
      if (r) begin
        for (int i = 7; i >= 0; i--) begin
          exp_q.push_back({READ, 1'b0});
          rd_q.push_back(rbyte[i]);
        end
        exp_q.push_back({WRITE, ai});
        exp_dout = rbyte;
      end else begin
        for (int i = 7; i >= 0; i--) exp_q.push_back({WRITE, d[i]});
        exp_q.push_back({READ, 1'b0});
        rd_q.push_back(ackbit);
        exp_dout = {8{dflt}};
        exp_ack_out = ackbit;
      end
    end else begin
      exp_dout = d;
    end
    if (p) exp_q.push_back({STOP, 1'b0});
    cmd_active = 1'b1;
    start = s; stop = p; read = r; write = w; ack_in = ai; din = d;
  endtask

  task automatic clear_cmd();
    start = 0; stop = 0; read = 0; write = 0; ack_in = 0;
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ack) begin got = 1; break; end
    end
    chk(name, got, 1);
    clear_cmd();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, base2;
    logic got;
    rst = 1; bit_al = 0; din = 8'h00;
    clear_cmd();
    repeat (3) @(negedge clk);
    chk("rst_bit_cmd", bit_cmd, NOP);
    chk("rst_dout", dout, 8'h00);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_i2c_al", i2c_al, 0);
    rst = 0;
    repeat (2) @(negedge clk);

    // 1: START + write A5, slave ACKs
    base = n_issued;
    issue(1, 0, 0, 1, 0, 8'hA5, 8'h00, 1'b0, 1'b0);
    wait_done("t1_done");
    chk("t1_ncmds", n_issued - base, 10);
    chk("t1_ack_out", ack_out, 0);
    chk("t1_dout", dout, 8'h00);

    // 2: read 3C, NACK, STOP
    base = n_issued; base2 = n_cack;
    issue(0, 1, 1, 0, 1, 8'h00, 8'h3C, 1'b0, 1'b1);
    wait_done("t2_done");
    chk("t2_dout", dout, 8'h3C);
    chk("t2_ack_out", ack_out, 0);
    chk("t2_ncmds", n_issued - base, 10);
    chk("t2_ncack", n_cack - base2, 1);

    // 3: stop only, then start alone
    base = n_issued;
    issue(0, 1, 0, 0, 0, 8'h3C, 8'h00, 1'b0, 1'b0);
    wait_done("t3_done");
    chk("t3_ncmds", n_issued - base, 1);
    chk("t3_dout", dout, 8'h3C);
    base = n_issued;
    start = 1;
    repeat (50) @(negedge clk);
    start = 0;
    chk("t3_start_alone", n_issued - base, 0);

    // 4: arbitration lost in the 4th bit of write FF, then write 81
    base = n_issued; base2 = n_cack;
    issue(0, 0, 0, 1, 0, 8'hFF, 8'h00, 1'b0, 1'b0);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_issued - base >= 4) begin got = 1; break; end
    end
    chk("t4_reach_bit4", got, 1);
    repeat (2) @(negedge clk);
    base = n_al;
    bit_al = 1;
    @(negedge clk);
    clear_cmd(); exp_q.delete(); rd_q.delete(); cmd_active = 0;
    repeat (2) @(negedge clk);
    bit_al = 0;
    repeat (5) @(negedge clk);
    chk("t4_al_pulses", n_al - base, 1);
    chk("t4_no_cmd_ack", n_cack - base2, 0);
    chk("t4_idle_nop", bit_cmd, NOP);
    issue(0, 0, 0, 1, 0, 8'h81, 8'h00, 1'b1, 1'b0);
    wait_done("t4_done");
    chk("t4_ack_out", ack_out, 1);

    // 6: read and write together executes as a read
    base = n_issued;
    issue(0, 0, 1, 1, 0, 8'h00, 8'hFF, 1'b0, 1'b0);
    wait_done("t6_done");
    chk("t6_dout", dout, 8'hFF);
    chk("t6_ack_out", ack_out, 1);
    chk("t6_ncmds", n_issued - base, 9);

    // 5: asynchronous reset after the 3rd read bit
    base = n_acks; base2 = n_cack;
    issue(0, 0, 1, 0, 0, 8'h00, 8'hE7, 1'b0, 1'b0);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_acks - base >= 3) begin got = 1; break; end
    end
    chk("t5_reach_ack3", got, 1);
    #3 rst = 1;
    #1;
    chk("t5_rst_bit_cmd", bit_cmd, NOP);
    chk("t5_rst_bit_din", bit_din, 0);
    chk("t5_rst_dout", dout, 8'h00);
    chk("t5_rst_ack_out", ack_out, 0);
    chk("t5_rst_cmd_ack", cmd_ack, 0);
    chk("t5_rst_i2c_al", i2c_al, 0);
    clear_cmd(); exp_q.delete(); rd_q.delete(); cmd_active = 0; exp_ack_out = 0;
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("t5_no_cmd_ack", n_cack - base2, 0);
    issue(0, 0, 1, 0, 0, 8'h00, 8'hFF, 1'b0, 1'b1);
    wait_done("t5_done");
    chk("t5_dout", dout, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
